resta_serial_nbit: RTL



---
 rtl/resta_pkg.sv | 12 +
 rtl/resta_1bit.sv | 13 +
 rtl/resta_serial_nbit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/resta_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package resta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } resta_state_t;

  localparam int RESTA_N_DEFAULT = 4;

endpackage

// File: rtl/resta_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow.
module resta_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/resta_serial_nbit.sv
// Bit-serial unsigned subtractor Diff = A - B, LSB first, start/done handshake.
// Optional Z/N/V flag outputs are enabled by defining RESTA_FLAGS_EN.
module resta_serial_nbit
  import resta_pkg::*;
#(
  parameter int n = RESTA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Diff,
  output logic         Bout,
`ifdef RESTA_FLAGS_EN
  output logic         Z,
  output logic         N,
  output logic         V,
`endif
  output logic         busy,
  output logic         done
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  resta_state_t  state_q, state_d;
  logic [n-1:0]  sa_q, sa_d;
  logic [n-1:0]  sb_q, sb_d;
  logic [n-1:0]  ds_q, ds_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic [n-1:0]  d_vec;
  logic [n-1:0]  ds_shift;
  logic          bit_d;
  logic          bit_bout;
  logic          last_bit;
`ifdef RESTA_FLAGS_EN
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic          v_q, v_d;
`endif

  resta_1bit u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt_q == CW'(n - 1));

  // Next-state, datapath shifting and result load on the final bit.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ds_d     = ds_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    d_vec    = '0;
    d_vec[n-1] = bit_d;
    // New bit enters at the MSB so after n shifts bit 0 sits at position 0.
    ds_shift = (ds_q >> 1) | d_vec;
`ifdef RESTA_FLAGS_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = A;
          sb_d    = B;
          ds_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef RESTA_FLAGS_EN
          a_msb_d = A[n-1];
          b_msb_d = B[n-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        ds_d  = ds_shift;
        br_d  = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          diff_d  = ds_shift;
          bout_d  = bit_bout;
`ifdef RESTA_FLAGS_EN
          z_d = (ds_shift == '0);
          n_d = ds_shift[n-1];
          v_d = (a_msb_q ^ b_msb_q) & (ds_shift[n-1] ^ a_msb_q);
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ds_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef RESTA_FLAGS_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ds_q    <= ds_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef RESTA_FLAGS_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
`endif
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
`ifdef RESTA_FLAGS_EN
  assign Z = z_q;
  assign N = n_q;
  assign V = v_q;
`endif

endmodule
